// File: rtl/psr_ctrl.sv
// psr_ctrl: processor status register with ALU flag updates, software
// whole-register writes and a hardware save/restore stack for interrupts.
// Optional build macro PSR_FWD_EN adds psr_fwd, a combinational view of the
// value psr will load at the next clock edge.
module psr_ctrl #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2,
  parameter int IE_IND      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp_f_en,
  input  logic             of_f_en,
  input  logic             z_f_en,
  input  logic             C_in,
  input  logic             L_in,
  input  logic             F_in,
  input  logic             Z_in,
  input  logic             N_in,
  input  logic             sw_we,
  input  logic [WIDTH-1:0] sw_wdata,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
`ifdef PSR_FWD_EN
  output logic [WIDTH-1:0] psr_fwd,
`endif
  output logic [WIDTH-1:0] psr,
  output logic [PTR_W:0]   depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int C_IND = 0;
  localparam int L_IND = 2;
  localparam int F_IND = 5;
  localparam int Z_IND = 6;
  localparam int N_IND = 7;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(STACK_DEPTH);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [WIDTH-1:0] psr_nxt;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             push_ok;
  logic             pop_ok;
  logic             err_set;

  assign stack_full  = (depth == FULL_CNT);
  assign stack_empty = (depth == '0);
  // Low pointer bits address the next free slot; the top entry sits one below.
  assign wr_idx = depth[PTR_W-1:0];
  assign rd_idx = wr_idx - PTR_W'(1);

`ifdef PSR_FWD_EN
  assign psr_fwd = psr_nxt;
`endif

  // Next-state decode: collision > pop > sw write > push > flag updates.
  always_comb begin
    psr_nxt = psr;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    err_set = 1'b0;
    if (push && pop) begin
      err_set = 1'b1;
    end else if (pop) begin
      if (stack_empty) begin
        err_set = 1'b1;
      end else begin
        pop_ok  = 1'b1;
        psr_nxt = stack_mem[rd_idx];
      end
    end else begin
      if (push) begin
        if (stack_full) err_set = 1'b1;
        else            push_ok = 1'b1;
      end
      if (sw_we) begin
        // Software data wins outright, including over the IE clear of a push.
        psr_nxt = sw_wdata;
      end else begin
        if (cmp_f_en) begin
          psr_nxt[L_IND] = L_in;
          psr_nxt[N_IND] = N_in;
        end
        if (of_f_en) begin
          psr_nxt[F_IND] = F_in;
          psr_nxt[C_IND] = C_in;
        end
        if (z_f_en) psr_nxt[Z_IND] = Z_in;
        if (push_ok) psr_nxt[IE_IND] = 1'b0;
      end
    end
  end

  // Architectural state: psr, occupancy and the sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psr       <= '0;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      psr <= psr_nxt;
      if (push_ok)     depth <= depth + (PTR_W+1)'(1);
      else if (pop_ok) depth <= depth - (PTR_W+1)'(1);
      if (err_set)      stack_err <= 1'b1;
      else if (clr_err) stack_err <= 1'b0;
    end
  end

  // Save slots hold the pre-update psr; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (push_ok) stack_mem[wr_idx] <= psr;
  end

endmodule

// File: doc/psr_ctrl.md
Name: psr_ctrl

Overview:
Next-generation processor status register for the datapath. It holds the five ALU flags (C, L, F, Z, N) plus an interrupt-enable bit. It adds software whole-register writes, for load/store-PSR instructions, and a parametrised hardware save/restore stack for interrupt entry and return. It sits beside the general-purpose register file; flag inputs come from the ALU, and control inputs come from the controller FSM.

Parameters:
WIDTH, 16, PSR width in bits (at least 10).
STACK_DEPTH, 4, number of PSR save slots (at least 1).
PTR_W, 2, stack pointer width; must satisfy 2**PTR_W >= STACK_DEPTH.
IE_IND, 9, bit index of the interrupt-enable flag.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
cmp_f_en  in  1  update L and N
of_f_en  in  1  update F and C
z_f_en  in  1  update Z
C_in, L_in, F_in, Z_in, N_in  in  1 each  flag values from the ALU
sw_we  in  1  software write of the whole PSR
sw_wdata  in  WIDTH  software write data
push  in  1  interrupt entry: save PSR, clear IE
pop  in  1  interrupt return: restore PSR from stack
clr_err  in  1  clear the sticky error
psr  out  WIDTH  registered PSR
depth  out  PTR_W+1  number of occupied stack slots
stack_full  out  1  high when depth == STACK_DEPTH
stack_empty  out  1  high when depth == 0
stack_err  out  1  sticky misuse flag

Behaviour:
- Fixed bit indices: C=0, L=2, F=5, Z=6, N=7, IE=IE_IND. All other bits change only via sw_we or pop.
- Reset (reset low, asynchronous): psr=0, depth=0, stack_err=0. Stack slot contents are don't-care. Reset asserted mid-sequence discards all saved entries.
- All state updates occur on the rising clk edge. psr reflects an update one cycle after the enable is sampled.
- Per-cycle priority, highest first:
  1. push and pop both high: illegal. psr, depth and stack are unchanged, and stack_err is set.
  2. pop:
     - if stack_empty: ignored, stack_err set.
     - otherwise: psr <= top entry and depth decrements. Flag enables and sw_we are ignored that cycle.
  3. sw_we: psr <= sw_wdata. Flag enables are ignored that cycle. A push in the same cycle is still processed as in item 4, and the push saves the pre-write psr.
  4. push:
     - if stack_full: no save, psr unchanged by the push, stack_err set.
     - otherwise: slot[depth] <= current psr (the value before any update this cycle) and depth increments.
     - In the same cycle psr[IE] <= 0, unless sw_we is also high; in that case sw_wdata wins entirely.
     - Flag enables still apply in a push cycle.
  5. Flag updates:
     - cmp_f_en writes L and N.
     - of_f_en writes F and C.
     - z_f_en writes Z.
     - Any combination may be active together, and all are independent of each other.
- stack_err stays high until clr_err or reset. When clr_err is high in the same cycle as a new error, the error wins.
- stack_full and stack_empty are decoded combinationally from the registered depth.
- A stack that is full never wraps; an empty stack never underflows the pointer.

Optional Feature:
PSR_FWD_EN
- Defined: adds output psr_fwd [WIDTH-1:0]. It is a combinational view of the value psr will take at the next edge, applying the full priority rules above, so the controller can branch on flags in the same cycle.
- Undefined: the psr_fwd port and its logic are absent.
- Registered behaviour is identical in both builds.

Test Plan:
1. Flag updates: release reset; cmp_f_en=1, of_f_en=1, L=1, N=1, C=1, F=0 -> psr=16'h0085. Next cycle z_f_en=1, Z=1 -> psr=16'h00C5.
2. Save and restore: sw_we with 16'h0200 (IE set); push -> psr=16'h0000, depth=1. Then z_f_en, Z=1 -> psr=16'h0040. Then pop -> psr=16'h0200, depth=0, stack_err=0.
3. Full stack: 4 pushes -> stack_full=1, depth=4. 5th push -> depth stays 4, stack_err=1. clr_err -> stack_err=0. 4 pops return the saved values in LIFO order, then stack_empty=1.
4. Empty-pop and collision: pop with depth=0 -> psr unchanged, stack_err=1. push and pop together with depth=1 -> depth stays 1, psr unchanged, stack_err=1.
5. Priority: pop with sw_we=1 (sw_wdata=16'hFFFF) and z_f_en=1 -> psr equals the popped entry. sw_we plus of_f_en -> psr=sw_wdata.
6. Async reset: assert reset mid-clock with depth=3 -> psr=0, depth=0 immediately, without waiting for a clock edge. With PSR_FWD_EN defined, psr_fwd matches the next psr in scenarios 1-5.
